// File: rtl/sn_psg_core_if.sv
// rtl/sn_psg_core_if.sv - command-byte write port and audio outputs of the PSG core
interface sn_psg_core_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [9:0] mix_out;
  logic       tick_out;

  modport master (output wr_en, wr_data, input mix_out, tick_out);
  modport slave  (input wr_en, wr_data, output mix_out, tick_out);
endinterface

// File: rtl/sn_psg_core.sv
// rtl/sn_psg_core.sv - SN76489-compatible tone/noise generator with registered PCM mixer
// Define PSG_ATTN_LOG_EN to select the 2 dB/step attenuation table instead of linear volume.
module sn_psg_core #(
  parameter int NUM_TONES = 3,
  parameter int FREQ_BITS = 10,
  parameter int CLK_DIV   = 16
) (
  input  logic         clk,
  input  logic         reset,
  sn_psg_core_if.slave bus
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = FREQ_BITS + 1;
  localparam int TL = NUM_TONES - 1;

  logic [PW-1:0]        presc;
  logic                 tick;
  logic [1:0]           latch_ch;
  logic                 latch_type;
  logic [3:0]           attn [4];
  logic [FREQ_BITS-1:0] freq [NUM_TONES];
  logic [CW-1:0]        tcnt [NUM_TONES];
  logic [NUM_TONES-1:0] tstate;
  logic [NUM_TONES-1:0] t_wrap;
  logic [2:0]           ctrl;
  logic [14:0]          lfsr;
  logic [14:0]          lfsr_next;
  logic [6:0]           ncnt;
  logic [6:0]           nper;
  logic                 nclk;
  logic                 n_wrap;
  logic                 n_shift;
  logic [9:0]           mix;
  logic [9:0]           mix_sum;
  logic                 is_latch;
  logic [1:0]           w_ch;
  logic                 w_type;
  logic                 freq_wr;
  logic                 noise_wr;

  function automatic logic [7:0] vol(input logic [3:0] a);
`ifdef PSG_ATTN_LOG_EN
    case (a)
      4'd0:    vol = 8'd255;
      4'd1:    vol = 8'd203;
      4'd2:    vol = 8'd161;
      4'd3:    vol = 8'd128;
      4'd4:    vol = 8'd102;
      4'd5:    vol = 8'd81;
      4'd6:    vol = 8'd64;
      4'd7:    vol = 8'd51;
      4'd8:    vol = 8'd40;
      4'd9:    vol = 8'd32;
      4'd10:   vol = 8'd26;
      4'd11:   vol = 8'd20;
      4'd12:   vol = 8'd16;
      4'd13:   vol = 8'd13;
      4'd14:   vol = 8'd10;
      default: vol = 8'd0;
    endcase
`else
    // 17*(15-a) is the inverted nibble repeated in both halves of the byte
    vol = {~a, ~a};
`endif
  endfunction

  // A data byte targets whatever the most recent latch byte selected
  always_comb begin
    is_latch = bus.wr_data[7];
    w_ch     = is_latch ? bus.wr_data[6:5] : latch_ch;
    w_type   = is_latch ? bus.wr_data[4]   : latch_type;
    freq_wr  = bus.wr_en && !w_type && (int'(w_ch) < NUM_TONES);
    noise_wr = bus.wr_en && !w_type && (w_ch == 2'd3);
  end

  always_comb begin
    for (int i = 0; i < NUM_TONES; i++)
      t_wrap[i] = tick && (tcnt[i] <= CW'(1));
    case (ctrl[1:0])
      2'b00:   nper = 7'd16;
      2'b01:   nper = 7'd32;
      default: nper = 7'd64;
    endcase
    n_wrap  = tick && (ctrl[1:0] != 2'b11) && (ncnt <= 7'd1);
    n_shift = (ctrl[1:0] == 2'b11) ? (t_wrap[TL] && !tstate[TL]) : (n_wrap && !nclk);
    lfsr_next = {ctrl[2] ? (lfsr[0] ^ lfsr[1]) : lfsr[0], lfsr[14:1]};
    if (lfsr_next == 15'd0)
      lfsr_next = 15'h4000;
    mix_sum = lfsr[0] ? {2'b00, vol(attn[3])} : 10'd0;
    for (int i = 0; i < NUM_TONES; i++)
      if (tstate[i])
        mix_sum = mix_sum + {2'b00, vol(attn[i])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      tick       <= 1'b0;
      latch_ch   <= 2'd0;
      latch_type <= 1'b0;
      for (int i = 0; i < 4; i++)
        attn[i] <= 4'hF;
      for (int i = 0; i < NUM_TONES; i++) begin
        freq[i] <= '0;
        tcnt[i] <= '0;
      end
      tstate <= '0;
      ctrl   <= 3'd0;
      lfsr   <= 15'h4000;
      ncnt   <= 7'd0;
      nclk   <= 1'b0;
      mix    <= 10'd0;
    end else begin
      tick  <= (presc == PW'(CLK_DIV - 1));
      presc <= (presc == PW'(CLK_DIV - 1)) ? '0 : presc + PW'(1);
      if (bus.wr_en && is_latch) begin
        latch_ch   <= bus.wr_data[6:5];
        latch_type <= bus.wr_data[4];
      end
      if (bus.wr_en && w_type)
        attn[w_ch] <= bus.wr_data[3:0];
      // Period writes land in freq only; the running counter picks them up at its next reload
      for (int i = 0; i < NUM_TONES; i++) begin
        if (t_wrap[i]) begin
          tcnt[i]   <= (freq[i] == '0) ? (CW'(1) << FREQ_BITS) : {1'b0, freq[i]};
          tstate[i] <= ~tstate[i];
        end else if (tick) begin
          tcnt[i] <= tcnt[i] - CW'(1);
        end
        if (freq_wr && (int'(w_ch) == i))
          freq[i] <= is_latch ? {freq[i][FREQ_BITS-1:4], bus.wr_data[3:0]}
                              : {bus.wr_data[FREQ_BITS-5:0], freq[i][3:0]};
      end
      if (n_wrap) begin
        ncnt <= nper;
        nclk <= ~nclk;
      end else if (tick && (ctrl[1:0] != 2'b11)) begin
        ncnt <= ncnt - 7'd1;
      end
      if (noise_wr) begin
        ctrl <= bus.wr_data[2:0];
        lfsr <= 15'h4000;
      end else if (n_shift) begin
        lfsr <= lfsr_next;
      end
      mix <= mix_sum;
    end
  end

  assign bus.mix_out  = mix;
  assign bus.tick_out = tick;
endmodule

// File: tb/tb_sn_psg_core.sv
// tb/tb_sn_psg_core.sv - directed vectors for sn_psg_core checked against a cycle-level behavioural model
module tb_sn_psg_core;
  logic clk = 1'b0;
  logic reset;
  sn_psg_core_if bus ();

  sn_psg_core #(.NUM_TONES(3), .FREQ_BITS(10), .CLK_DIV(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit check_en    = 1'b0;

  int m_presc, m_lch, m_ltype, m_ctrl, m_lfsr, m_nrem, m_mix;
  bit m_tick, m_nlev;
  int m_attn [4];
  int m_freq [3];
  int m_rem  [3];
  bit m_st   [3];

  function automatic int volf(int a);
`ifdef PSG_ATTN_LOG_EN
    int tbl [16] = '{255, 203, 161, 128, 102, 81, 64, 51, 40, 32, 26, 20, 16, 13, 10, 0};
    return tbl[a];
`else
    return 17 * (15 - a);
`endif
  endfunction

  function automatic int half_period(int f);
    return (f == 0) ? 1024 : f;
  endfunction

  task automatic model_reset();
    m_presc = 0; m_tick = 0; m_lch = 0; m_ltype = 0;
    m_ctrl = 0; m_lfsr = 'h4000; m_nrem = 1; m_nlev = 0; m_mix = 0;
    for (int i = 0; i < 4; i++) m_attn[i] = 15;
    for (int i = 0; i < 3; i++) begin
      m_freq[i] = 0; m_rem[i] = 1; m_st[i] = 0;
    end
  endtask

  // Ticks-remaining view of each generator; a write lands after this cycle's generator update
  task automatic model_step(bit rst, bit we, logic [7:0] b);
    int nmix, ch, ty, fb;
    bit rise, shift;
    if (rst) begin
      model_reset();
      return;
    end
    nmix = (m_lfsr & 1) ? volf(m_attn[3]) : 0;
    for (int i = 0; i < 3; i++) if (m_st[i]) nmix += volf(m_attn[i]);
    rise = 0; shift = 0;
    if (m_tick) begin
      for (int i = 0; i < 3; i++) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_st[i]  = !m_st[i];
          m_rem[i] = half_period(m_freq[i]);
          if (i == 2 && m_st[i]) rise = 1;
        end
      end
      if (m_ctrl % 4 != 3) begin
        m_nrem--;
        if (m_nrem == 0) begin
          m_nlev = !m_nlev;
          m_nrem = 16 << (m_ctrl % 4);
          shift  = m_nlev;
        end
      end else begin
        shift = rise;
      end
    end
    if (shift) begin
      fb = (m_ctrl & 4) ? ((m_lfsr ^ (m_lfsr >> 1)) & 1) : (m_lfsr & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << 14);
    end
    if (we) begin
      if (b[7]) begin
        ch = int'(b[6:5]); ty = int'(b[4]); m_lch = ch; m_ltype = ty;
      end else begin
        ch = m_lch; ty = m_ltype;
      end
      if (ty != 0) m_attn[ch] = int'(b[3:0]);
      else if (ch == 3) begin
        m_ctrl = int'(b[2:0]); m_lfsr = 'h4000;
      end else if (b[7]) m_freq[ch] = (m_freq[ch] & 'h3F0) | int'(b[3:0]);
      else m_freq[ch] = int'(b[5:0]) * 16 + (m_freq[ch] & 'hF);
    end
    m_tick  = (m_presc == 15);
    m_presc = (m_presc + 1) % 16;
    m_mix   = nmix;
  endtask

  always @(posedge clk) model_step(reset, bus.wr_en, bus.wr_data);
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (check_en) begin
      vectors++;
      if (bus.mix_out !== 10'(m_mix)) begin
        miscompares++;
        $display("FAIL mix_out cyc=%0d actual %0d required %0d", cyc, bus.mix_out, m_mix);
      end
      vectors++;
      if (bus.tick_out !== m_tick) begin
        miscompares++;
        $display("FAIL tick_out cyc=%0d actual %0b required %0b", cyc, bus.tick_out, m_tick);
      end
    end
  end

  task automatic run_to(int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic put(logic [7:0] b);
    bus.wr_en = 1'b1; bus.wr_data = b;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.wr_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_int(string name, int got, int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual %0d required %0d", name, cyc, got, want);
    end
  endtask

  // Pins both the DUT and the model to a hand-derived mix_out value
  task automatic lit(string name, int want);
    chk_int({name, "_dut"}, int'(bus.mix_out), want);
    chk_int({name, "_model"}, m_mix, want);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual timeout required completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ticks, first_tick, max_mix, hi;
    reset = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h90;
    @(negedge clk);
    check_en = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; reset = 1'b0;

    lit("reset_mix", 0);
    chk_int("reset_tick", int'(bus.tick_out), 0);
    ticks = 0; first_tick = 0; max_mix = 0;
    for (int i = 1; i <= 1000; i++) begin
      run_to(i);
      if (bus.tick_out) begin
        ticks++;
        if (first_tick == 0) first_tick = cyc;
      end
      if (int'(bus.mix_out) > max_mix) max_mix = int'(bus.mix_out);
    end
    chk_int("idle_tick_count", ticks, 62);
    chk_int("idle_first_tick", first_tick, 16);
    chk_int("idle_max_mix", max_mix, 0);

    do_reset();
    put(8'h8A); put(8'h01); put(8'h90);
    run_to(17);  lit("ch0_pre_toggle", 0);
    run_to(18);  lit("ch0_high", 255);
    run_to(433); lit("ch0_high_end", 255);
    run_to(434); lit("ch0_low", 0);
    run_to(849); lit("ch0_low_end", 0);
    run_to(850); lit("ch0_high2", 255);

    do_reset();
    put(8'h8A); put(8'h01); put(8'hAA); put(8'h01); put(8'h9F); put(8'hB0);
    run_to(18);  lit("two_ch_peak", 255);
    run_to(100); put(8'h90);
    lit("attn_wr_same_cycle", 255);
    run_to(102); lit("attn_wr_plus1", 510);
    put(8'h92);
    run_to(104); lit("attn2_peak", 255 + volf(2));
`ifdef PSG_ATTN_LOG_EN
    chk_int("log_attn2", volf(2), 161);
`else
    chk_int("lin_attn2", volf(2), 221);
`endif
    run_to(434); lit("two_ch_low", 0);

    do_reset();
    put(8'hF0); put(8'hE4);
    run_to(6673); lit("white_shift14_pre", 0);
    run_to(6674); lit("white_shift14", 255);
    run_to(7185); lit("white_shift15_pre", 255);
    run_to(7186); lit("white_shift15", 0);

    do_reset();
    put(8'hC1); put(8'h00); put(8'hF0); put(8'hE7);
    run_to(80); put(8'hE7);
    run_to(529); lit("reload_wins_pre", 0);
    run_to(530); lit("reload_wins", 255);
    run_to(81 + 32 * 200 + 40);
    put(8'hE3);
    repeat (64) @(negedge clk);
    hi = 0;
    for (int k = 0; k < 1920; k++) begin
      @(negedge clk);
      if (bus.mix_out == 10'd255) hi++;
    end
    chk_int("periodic_high_cycles", hi, 128);
    put(8'hE0);
    repeat (1000) @(negedge clk);
    put(8'hE3);
    repeat (200) @(negedge clk);
    do_reset();
    lit("midrun_reset_mix", 0);
    chk_int("midrun_reset_tick", int'(bus.tick_out), 0);
    put(8'hF0);
    run_to(6673); lit("reset_lfsr_pre", 0);
    run_to(6674); lit("reset_lfsr_shift14", 255);
    run_to(7186); lit("reset_lfsr_shift15", 0);

    do_reset();
    put(8'hA0); put(8'hB0);
    run_to(18);    lit("ch1_f0_high", 255);
    run_to(4999);  put(8'hA5);
    run_to(16401); lit("ch1_1024_end", 255);
    run_to(16402); lit("ch1_low", 0);
    run_to(16481); lit("ch1_5tick_end", 0);
    run_to(16482); lit("ch1_high_again", 255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sn_psg_core.md
# sn_psg_core

Parametrised SN76489-compatible programmable sound generator core. It has up to three square-wave tone channels and one LFSR noise channel, each with 4-bit attenuation. Channels are programmed through the standard SN76489 latch/data byte protocol and summed into one registered unsigned PCM sample. It replaces the fixed-register tone bank as the audio engine behind the TinyTapeout top level.

## Interface
- NUM_TONES, 3: tone channels instantiated, 1..3; channel codes >= NUM_TONES (other than 3) are ignored.
- FREQ_BITS, 10: tone period register width.
- CLK_DIV, 16: master clocks per generator tick, >= 2.
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- wr_en  input  1  write strobe; one byte is accepted per cycle, no backpressure.
- wr_data  input  8  SN76489 command byte.
- mix_out  output  10  registered sum of four 8-bit channel amplitudes.
- tick_out  output  1  one-cycle pulse on each generator tick (debug).

## Operation
- Latch byte (wr_data[7]=1):
  - ch=wr_data[6:5], type=wr_data[4] (1=attenuation), low nibble=wr_data[3:0].
  - ch/type are stored in the latch register.
  - Tone freq: the low nibble writes freq[3:0].
  - Attenuation: the low nibble writes attn[ch].
  - Noise (ch 3, type 0): writes ctrl[2:0] and reloads the LFSR.
- Data byte (wr_data[7]=0) applies to the latched target:
  - Tone freq: freq[9:4]=wr_data[5:0].
  - Attenuation: attn=wr_data[3:0].
  - Noise: ctrl=wr_data[2:0] and the LFSR reloads.
- Prescaler: counts 0..CLK_DIV-1 and asserts tick when it wraps to 0.
- Tone channel: the down-counter decrements on each tick. When the counter is <=1 on a tick, it reloads freq and toggles the channel state. freq=0 behaves as 1024 (2^FREQ_BITS). A freq write does not disturb the counter; the new value takes effect at the next reload.
- Noise channel:
  - Rate ctrl[1:0]: 00/01/10 give a half-period counter of 16/32/64 ticks. 11 clocks the noise from the rising edge of tone channel NUM_TONES-1.
  - The 15-bit LFSR shifts right on each rising edge of the noise clock.
  - Feedback into bit14: ctrl[2]=1 (white) uses bit0^bit1; ctrl[2]=0 (periodic) uses bit0.
  - The LFSR reload value is 0x4000, and it must never lock at 0.
  - Noise channel state is LFSR bit0.
- Amplitude per channel: state ? vol(attn) : 0. attn=15 always gives 0.
- Linear volume: vol = 17*(15-attn), giving 255..0 in steps of 17.
- Mixer: mix_out = sum of the NUM_TONES tone amplitudes plus the noise amplitude, 10-bit unsigned, so no overflow is possible (max 1020).

## Timing
- Reset values:
  - mix_out=0, tick_out=0.
  - All attn=15, all freq=0, ctrl=0, LFSR=0x4000.
  - Tone states and counters 0, prescaler 0, latch ch=0/type=0.
- A write takes effect in the register on the clock edge where wr_en=1. The amplitude change is visible on mix_out one cycle later, so latency from write to mix_out is 2 clocks.
- mix_out is registered; a state toggle on a tick appears on mix_out at the next edge.
- If a noise write and a noise shift land in the same cycle, the reload wins.
- Reset mid-operation returns every register to its reset value on the same edge. wr_en is ignored while reset=1.
- Back-to-back writes: each byte is processed in order. A data byte uses the latch state updated by the previous cycle's latch byte.

## Configuration
- PSG_ATTN_LOG_EN defined: vol comes from a 2 dB/step table indexed by attn: 255,203,161,128,102,81,64,51,40,32,26,20,16,13,10,0.
- PSG_ATTN_LOG_EN undefined: linear 17*(15-attn) as described above.
- The rest of the datapath is identical in both builds.

## Test plan
- Reset, then run 1000 clocks with no writes -> mix_out stays 0, and tick_out pulses every 16 clocks.
- Write 0x8A, 0x01, 0x90 (ch0 freq=0x01A, attn 0) -> ch0 toggles every 26 ticks (416 clocks); mix_out alternates 0/255.
- Set attn 0x9F, 0xB0 on two channels at equal freq -> mix_out peaks 255. With PSG_ATTN_LOG_EN, set attn=2 on one channel -> the peak is 161.
- Write noise 0xE4 (white, rate 00) with attn 0xF0 -> the LFSR sequence from 0x4000 matches the bit0^bit1 model over 200 shifts. Then write 0xE0 -> the sequence is periodic with period 15 shifts.
- Set freq=0 on ch1 -> half-period is 1024 ticks. Then write 0xA5 mid-count -> the current half-period completes unchanged, and the next half-period is 5 ticks.
- Assert reset during active playback with noise ctrl=11 -> all outputs return to 0 the next cycle, and the LFSR reads 0x4000.
